// File: rtl/max_tree_pipe.sv
// max_tree_pipe
//   Pipelined signed max/min reduction over N_CH stream channels. A balanced
//   binary comparison tree has one register level per tree level. It returns
//   the winning value and its channel index, and a peak-hold register tracks
//   the extreme value seen across valid samples until it is cleared.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   i_valid      sample on i_data/i_mode is valid this cycle
//   i_data       packed signed channels, ch k = i_data[k*WIDTH +: WIDTH]
//   i_mode       0 = maximum, 1 = minimum; travels with its sample
//   i_peak_clr   synchronous clear of the peak-hold
//   o_valid      o_data/o_idx valid (LAT cycles after the sample edge)
//   o_data       winning value (held while o_valid = 0)
//   o_idx        channel index of the winner
//   o_peak       peak-hold value
//   o_peak_idx   channel index of the peak-hold value
//   o_peak_vld   peak-hold contains at least one sample since clear/reset
module max_tree_pipe #(
    parameter int WIDTH = 14,
    parameter int N_CH  = 8,
    localparam int IDX_W = $clog2(N_CH),
    localparam int LAT   = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    input  logic [N_CH*WIDTH-1:0]   i_data,
    input  logic                    i_mode,
    input  logic                    i_peak_clr,
    output logic                    o_valid,
    output logic signed [WIDTH-1:0] o_data,
    output logic [IDX_W-1:0]        o_idx,
    output logic signed [WIDTH-1:0] o_peak,
    output logic [IDX_W-1:0]        o_peak_idx,
    output logic                    o_peak_vld
);

    // Number of entries at tree level lvl; an odd entry is carried upward.
    function automatic int cnt_at(input int lvl);
        int c;
        c = N_CH;
        for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
        return c;
    endfunction

    for (genvar l = 0; l <= LAT; l++) begin : g_lvl
        localparam int CNT = cnt_at(l);

        logic signed [WIDTH-1:0] v  [CNT];
        logic [IDX_W-1:0]        ix [CNT];
        logic                    m;
        logic                    vld;

        if (l == 0) begin : g_in
            for (genvar j = 0; j < CNT; j++) begin : g_ch
                assign v[j]  = i_data[j*WIDTH +: WIDTH];
                assign ix[j] = IDX_W'(j);
            end
            assign m   = i_mode;
            assign vld = i_valid;
        end else begin : g_node
            localparam int PCNT = cnt_at(l - 1);

            logic signed [WIDTH-1:0] nv [CNT];
            logic [IDX_W-1:0]        ni [CNT];

            for (genvar j = 0; j < CNT; j++) begin : g_pair
                if (2*j + 1 < PCNT) begin : g_cmp
                    // The left entry always covers lower channel indices, so
                    // keeping it on equality gives the lower-index tie rule.
                    logic take_b;
                    assign take_b = g_lvl[l-1].m
                                  ? (g_lvl[l-1].v[2*j+1] < g_lvl[l-1].v[2*j])
                                  : (g_lvl[l-1].v[2*j+1] > g_lvl[l-1].v[2*j]);
                    assign nv[j] = take_b ? g_lvl[l-1].v[2*j+1]  : g_lvl[l-1].v[2*j];
                    assign ni[j] = take_b ? g_lvl[l-1].ix[2*j+1] : g_lvl[l-1].ix[2*j];
                end else begin : g_pass
                    assign nv[j] = g_lvl[l-1].v[2*j];
                    assign ni[j] = g_lvl[l-1].ix[2*j];
                end
            end

            // Inner levels load every clock; the output level loads only on a
            // valid sample so o_data/o_idx hold between results.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld <= 1'b0;
                    m   <= 1'b0;
                    for (int k = 0; k < CNT; k++) begin
                        v[k]  <= '0;
                        ix[k] <= '0;
                    end
                end else begin
                    vld <= g_lvl[l-1].vld;
                    if ((l < LAT) || g_lvl[l-1].vld) begin
                        v  <= nv;
                        ix <= ni;
                        m  <= g_lvl[l-1].m;
                    end
                end
            end

            if (l == LAT) begin : g_peak
                // Evaluated on the winner entering the output register so the
                // peak updates on the same edge that raises o_valid.
                logic better;
                assign better = g_lvl[l-1].m ? (nv[0] < o_peak) : (nv[0] > o_peak);

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        o_peak     <= '0;
                        o_peak_idx <= '0;
                        o_peak_vld <= 1'b0;
                    end else if (g_lvl[l-1].vld) begin
                        if (!o_peak_vld || i_peak_clr || better) begin
                            o_peak     <= nv[0];
                            o_peak_idx <= ni[0];
                        end
                        o_peak_vld <= 1'b1;
                    end else if (i_peak_clr) begin
                        o_peak     <= '0;
                        o_peak_idx <= '0;
                        o_peak_vld <= 1'b0;
                    end
                end
            end
        end
    end

    assign o_valid = g_lvl[LAT].vld;
    assign o_data  = g_lvl[LAT].v[0];
    assign o_idx   = g_lvl[LAT].ix[0];

endmodule

// File: tb/tb_max_tree_pipe.sv
module tb_max_tree_pipe;
    localparam int W = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic v8 = 0, m8 = 0, c8 = 0;
    logic [8*W-1:0] d8 = '0;
    logic ov8, opv8;
    logic signed [W-1:0] od8, op8;
    logic [2:0] oi8, opi8;

    logic v5 = 0, m5 = 0, c5 = 0;
    logic [5*W-1:0] d5 = '0;
    logic ov5, opv5;
    logic signed [W-1:0] od5, op5;
    logic [2:0] oi5, opi5;

    logic v2 = 0, m2 = 0, c2 = 0;
    logic [2*W-1:0] d2 = '0;
    logic ov2, opv2;
    logic signed [W-1:0] od2, op2;
    logic [0:0] oi2, opi2;

    max_tree_pipe #(.WIDTH(W), .N_CH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .i_valid(v8), .i_data(d8), .i_mode(m8),
        .i_peak_clr(c8), .o_valid(ov8), .o_data(od8), .o_idx(oi8),
        .o_peak(op8), .o_peak_idx(opi8), .o_peak_vld(opv8));
    max_tree_pipe #(.WIDTH(W), .N_CH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .i_valid(v5), .i_data(d5), .i_mode(m5),
        .i_peak_clr(c5), .o_valid(ov5), .o_data(od5), .o_idx(oi5),
        .o_peak(op5), .o_peak_idx(opi5), .o_peak_vld(opv5));
    max_tree_pipe #(.WIDTH(W), .N_CH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_valid(v2), .i_data(d2), .i_mode(m2),
        .i_peak_clr(c2), .o_valid(ov2), .o_data(od2), .o_idx(oi2),
        .o_peak(op2), .o_peak_idx(opi2), .o_peak_vld(opv2));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic v;
        int   val;
        int   idx;
        logic m;
    } res_t;
    res_t q[$];

    // Behavioural model of dut8 outputs
    int   m_data = 0, m_idx = 0, m_pk = 0, m_pki = 0;
    logic m_ov = 0, m_pv = 0;

    int vec[8];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Winner by linear scan: first channel wins unless a later one is strictly better.
    function automatic void ref_win(input int ch[8], input int n, input logic md,
                                    output int val, output int idx);
        val = ch[0];
        idx = 0;
        for (int k = 1; k < n; k++)
            if (md ? (ch[k] < val) : (ch[k] > val)) begin
                val = ch[k];
                idx = k;
            end
    endfunction

    function automatic logic [8*W-1:0] pack(input int ch[8]);
        logic [8*W-1:0] d;
        d = '0;
        for (int k = 0; k < 8; k++) d[k*W +: W] = ch[k][W-1:0];
        return d;
    endfunction

    task automatic model_reset();
        q.delete();
        m_data = 0; m_idx = 0; m_pk = 0; m_pki = 0; m_ov = 0; m_pv = 0;
    endtask

    task automatic check8(input string tag);
        chk({tag, "_ovalid"}, int'(ov8), int'(m_ov));
        chk({tag, "_odata"},  int'(od8), m_data);
        chk({tag, "_oidx"},   int'(oi8), m_idx);
        chk({tag, "_peak"},   int'(op8), m_pk);
        chk({tag, "_peakidx"}, int'(opi8), m_pki);
        chk({tag, "_peakvld"}, int'(opv8), int'(m_pv));
    endtask

    // One clock of dut8 with scoreboard update and full output comparison.
    task automatic step8(input string tag, input logic v, input int ch[8],
                         input logic md, input logic clr);
        int val, idx;
        res_t r;
        v8 = v; d8 = pack(ch); m8 = md; c8 = clr;
        @(posedge clk);
        ref_win(ch, 8, md, val, idx);
        q.push_back('{v, val, idx, md});
        if (q.size() == 3) begin
            r = q.pop_front();
            m_ov = r.v;
            if (r.v) begin
                m_data = r.val;
                m_idx  = r.idx;
                if (!m_pv || clr || (r.m ? (r.val < m_pk) : (r.val > m_pk))) begin
                    m_pk  = r.val;
                    m_pki = r.idx;
                end
                m_pv = 1;
            end else if (clr) begin
                m_pk = 0; m_pki = 0; m_pv = 0;
            end
        end else if (clr) begin
            m_pk = 0; m_pki = 0; m_pv = 0;
        end
        #1;
        check8(tag);
    endtask

    task automatic idle8(input string tag, input int n);
        int z[8];
        z = '{default: 0};
        for (int i = 0; i < n; i++) step8(tag, 1'b0, z, 1'b0, 1'b0);
    endtask

    initial begin
        int t5[8];
        int t1v[8];
        logic [8*W-1:0] tmp;

        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        check8("reset");
        chk("reset_ov5", int'(ov5), 0);
        chk("reset_ov2", int'(ov2), 0);
        rst_n = 1'b1;

        // Main vector, max then min, with exact latency
        t1v = '{5, -3, 100, 7, -8192, 8191, 0, 2};
        step8("t1_s", 1'b1, t1v, 1'b0, 1'b0);
        idle8("t1_w", 2);
        chk("t1_data_const", int'(od8), 8191);
        chk("t1_idx_const", int'(oi8), 5);
        idle8("t1_hold", 1);
        chk("t1_hold_const", int'(od8), 8191);
        step8("t2_s", 1'b1, t1v, 1'b1, 1'b0);
        idle8("t2_w", 2);
        chk("t2_data_const", int'(od8), -8192);
        chk("t2_idx_const", int'(oi8), 4);

        // Back-to-back alternating mode
        for (int i = 0; i < 6; i++) step8("b2b", 1'b1, t1v, i[0], 1'b0);
        idle8("b2b_w", 3);

        // Ties
        vec = '{default: -1};
        step8("tie_m0", 1'b1, vec, 1'b0, 1'b0);
        step8("tie_m1", 1'b1, vec, 1'b1, 1'b0);
        vec = '{0, 0, 0, 50, 0, 0, 50, 0};
        step8("tie_50", 1'b1, vec, 1'b0, 1'b0);
        chk("tie_m0_idx_const", int'(oi8), 0);
        idle8("tie_w", 1);
        chk("tie_m1_idx_const", int'(oi8), 0);
        idle8("tie_w", 1);
        chk("tie_50_idx_const", int'(oi8), 3);

        // Peak-hold: maxima 3, 9 (ch5), 9 (ch2), 4
        vec = '{default: 0};
        step8("pk_clr", 1'b0, vec, 1'b0, 1'b1);
        chk("pk_clr_vld_const", int'(opv8), 0);
        vec = '{0, 3, 0, 0, 0, 0, 0, 0};  step8("pk1", 1'b1, vec, 1'b0, 1'b0);
        vec = '{0, 0, 0, 0, 0, 9, 0, 0};  step8("pk2", 1'b1, vec, 1'b0, 1'b0);
        vec = '{0, 0, 9, 0, 0, 0, 0, 0};  step8("pk3", 1'b1, vec, 1'b0, 1'b0);
        chk("pk1_const", int'(op8), 3);
        vec = '{4, 0, 0, 0, 0, 0, 0, 0};  step8("pk4", 1'b1, vec, 1'b0, 1'b0);
        chk("pk2_const", int'(op8), 9);
        idle8("pk_w", 1);
        chk("pk3_const", int'(op8), 9);
        chk("pk3_idx_const", int'(opi8), 5);
        idle8("pk_w", 1);
        chk("pk4_const", int'(op8), 9);
        // Clear coincident with the max-4 sample reaching the output
        step8("pkc", 1'b1, vec, 1'b0, 1'b0);
        idle8("pkc_w", 1);
        vec = '{default: 0};
        step8("pkc_clr", 1'b0, vec, 1'b0, 1'b1);
        chk("pkc_peak_const", int'(op8), 4);
        chk("pkc_vld_const", int'(opv8), 1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 8; k++)
                if (i < 150) vec[k] = int'($signed(W'($urandom())));
                else vec[k] = int'($urandom_range(0, 6)) - 3;
            step8("rnd", 1'($urandom_range(0, 3) != 0), vec, 1'($urandom()),
                  1'($urandom_range(0, 15) == 0));
        end

        // Reset with samples in flight
        for (int i = 0; i < 3; i++) step8("fl", 1'b1, t1v, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_ov", int'(ov8), 0);
        chk("rst_od", int'(od8), 0);
        chk("rst_oi", int'(oi8), 0);
        chk("rst_pk", int'(op8), 0);
        chk("rst_pki", int'(opi8), 0);
        chk("rst_pv", int'(opv8), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle8("post_rst", 5);

        // Odd channel count: N_CH=5
        t5 = '{10, 10, 10, 10, 20, 0, 0, 0};
        tmp = pack(t5);
        d5 = tmp[5*W-1:0]; m5 = 1'b0; v5 = 1'b1;
        @(posedge clk); #1; v5 = 1'b0;
        chk("n5_lat1", int'(ov5), 0);
        @(posedge clk); #1;
        chk("n5_lat2", int'(ov5), 0);
        @(posedge clk); #1;
        chk("n5_ov", int'(ov5), 1);
        chk("n5_data", int'(od5), 20);
        chk("n5_idx", int'(oi5), 4);
        chk("n5_peak", int'(op5), 20);
        m5 = 1'b1; v5 = 1'b1;
        @(posedge clk); #1; v5 = 1'b0;
        chk("n5_hold_ov", int'(ov5), 0);
        chk("n5_hold_data", int'(od5), 20);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("n5_min_data", int'(od5), 10);
        chk("n5_min_idx", int'(oi5), 0);

        // Two channels: LAT=1
        d2 = {14'(-1), 14'(-2)}; m2 = 1'b0; v2 = 1'b1;
        @(posedge clk); #1;
        chk("n2_ov", int'(ov2), 1);
        chk("n2_data", int'(od2), -1);
        chk("n2_idx", int'(oi2), 1);
        m2 = 1'b1;
        @(posedge clk); #1; v2 = 1'b0;
        chk("n2_min_data", int'(od2), -2);
        chk("n2_min_idx", int'(oi2), 0);
        chk("n2_peak", int'(op2), -2);
        @(posedge clk); #1;
        chk("n2_idle_ov", int'(ov2), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
